// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one serial SPI SRAM between two requesters (port 0: CPU path,
//   port 1: DMA/peripheral master). Each accepted request becomes one
//   complete sequential-mode SPI transaction: command byte, address bytes,
//   then 1/2/4 data bytes. SPI mode 0 (sclk idles low).
//
// Ports
//   clk, resetn              system clock, asynchronous active-low reset
//   reqN, weN, sizeN         request, write(1)/read(0), size (0=1B,1=2B,2/3=4B)
//   addrN, wdataN            byte address, little-endian write data
//   gntN, doneN              one-cycle accept / completion pulses
//   rdata                    read data, updated in the done cycle of a read
//   sclk, si, so, sram_ce    SPI pins (sram_ce active low)
//
// Build option
//   SRAM_ARB_FIXED_PRIO_EN   when defined, port 0 always wins simultaneous
//                            requests (no round-robin state). Port 1 can starve.
module sram_arbiter #(
    parameter int         ADDR_BYTES = 3,
    parameter int         HALF_DIV   = 1,
    parameter logic [7:0] CMD_READ   = 8'h03,
    parameter logic [7:0] CMD_WRITE  = 8'h02
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic        we0,
    input  logic [1:0]  size0,
    input  logic [23:0] addr0,
    input  logic [31:0] wdata0,
    output logic        gnt0,
    output logic        done0,
    input  logic        req1,
    input  logic        we1,
    input  logic [1:0]  size1,
    input  logic [23:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt1,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        si,
    input  logic        so,
    output logic        sram_ce
);

    localparam int               DIV_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [5:0]       ADDR_BITS = 6'(8 * ADDR_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;      // bits left in the current phase
    logic             port_r;
    logic             we_r;
    logic [5:0]       data_bits_r;  // 8 * byte count of the latched request
    logic [62:0]      sh;           // outgoing bits still to be placed on si
    logic [31:0]      rx;           // read bits, first byte ends up highest
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic             rr_last;      // port granted most recently
`endif

    // Whole outgoing frame, left aligned: cmd, address, data bytes in
    // address order (little-endian), each MSB first. Reads send zeros.
    function automatic logic [63:0] build_frame(input logic we, input logic [1:0] size,
                                                input logic [23:0] addr, input logic [31:0] wdata);
        logic [7:0]  cmd;
        logic [31:0] d;
        logic [31:0] payload;
        cmd = we ? CMD_WRITE : CMD_READ;
        d   = '0;
        if (we) begin
            case (size)
                2'd0:    d[7:0]  = wdata[7:0];
                2'd1:    d[15:0] = wdata[15:0];
                default: d       = wdata;
            endcase
        end
        payload = {d[7:0], d[15:8], d[23:16], d[31:24]};
        if (ADDR_BYTES == 2)
            return {cmd, addr[15:0], payload, 8'h00};
        else
            return {cmd, addr, payload};
    endfunction

    function automatic logic [5:0] data_bits(input logic [1:0] size);
        case (size)
            2'd0:    return 6'd8;
            2'd1:    return 6'd16;
            default: return 6'd32;  // size 3 is treated as 4 bytes
        endcase
    endfunction

    // rx holds the first received byte in its most significant used byte;
    // byte k belongs at rdata[8k+7:8k].
    function automatic logic [31:0] unpack_rdata(input logic [31:0] r, input logic [5:0] nbits);
        case (nbits)
            6'd8:    return {24'h0, r[7:0]};
            6'd16:   return {16'h0, r[7:0], r[15:8]};
            default: return {r[7:0], r[15:8], r[23:16], r[31:24]};
        endcase
    endfunction

    logic        win_any;
    logic        win_port;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [63:0] sel_frame;
    logic        bit_active;
    logic        rise;
    logic        fall;

    always_comb begin
        win_any = req0 | req1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        win_port = ~req0;
`else
        if (req0 && req1)
            win_port = ~rr_last;
        else
            win_port = ~req0;
`endif
        sel_we    = win_port ? we1 : we0;
        sel_size  = win_port ? size1 : size0;
        sel_frame = win_port ? build_frame(we1, size1, addr1, wdata1)
                             : build_frame(we0, size0, addr0, wdata0);

        // bit_cnt==0 in DATA is the trailing low cycle before DONE
        bit_active = (state == S_CMD || state == S_ADDR || state == S_DATA) && (bit_cnt != 6'd0);
        rise       = bit_active && !sclk && (div_cnt == DIV_LAST);
        fall       = bit_active &&  sclk && (div_cnt == DIV_LAST);
    end

    // Control: arbitration, sequencing and SPI pin timing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            sclk        <= 1'b0;
            si          <= 1'b0;
            sram_ce     <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata       <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            port_r      <= 1'b0;
            we_r        <= 1'b0;
            data_bits_r <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_last     <= 1'b1;
`endif
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;

            if (bit_active) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        port_r      <= win_port;
                        we_r        <= sel_we;
                        data_bits_r <= data_bits(sel_size);
                        gnt0        <= ~win_port;
                        gnt1        <= win_port;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        rr_last     <= win_port;
`endif
                        sram_ce     <= 1'b0;
                        si          <= sel_frame[63];
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bit_cnt <= 6'd8;
                    div_cnt <= '0;
                    state   <= S_CMD;
                end
                S_CMD: begin
                    if (fall) begin
                        si <= sh[62];
                        if (bit_cnt == 6'd1) begin
                            bit_cnt <= ADDR_BITS;
                            state   <= S_ADDR;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (fall) begin
                        si <= sh[62];
                        if (bit_cnt == 6'd1) begin
                            bit_cnt <= data_bits_r;
                            state   <= S_DATA;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_cnt == 6'd0) begin
                        sram_ce <= 1'b1;
                        done0   <= ~port_r;
                        done1   <= port_r;
                        if (!we_r)
                            rdata <= unpack_rdata(rx, data_bits_r);
                        state   <= S_DONE;
                    end else if (fall) begin
                        si      <= sh[62];
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    si    <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath shift registers: loaded at grant, no reset needed
    always_ff @(posedge clk) begin
        if (state == S_IDLE && win_any) begin
            sh <= sel_frame[62:0];
            rx <= '0;
        end else begin
            if (fall)
                sh <= {sh[61:0], 1'b0};
            if (rise && state == S_DATA)
                rx <= {rx[30:0], so};
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SPI SRAM model.
// Two DUT instances share the model: HALF_DIV=1 (main) and HALF_DIV=3.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel = 1'b0;            // 0: HALF_DIV=1 instance, 1: HALF_DIV=3
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [1:0]  size0 = 0, size1 = 0;
    logic [23:0] addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        so_m = 1'b0;

    logic        gnt0_a, gnt1_a, done0_a, done1_a, sclk_a, si_a, ce_a;
    logic        gnt0_b, gnt1_b, done0_b, done1_b, sclk_b, si_b, ce_b;
    logic [31:0] rdata_a, rdata_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.ADDR_BYTES(3), .HALF_DIV(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .req0(req0 & ~sel), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_a), .done0(done0_a),
        .req1(req1 & ~sel), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_a), .done1(done1_a),
        .rdata(rdata_a), .sclk(sclk_a), .si(si_a), .so(so_m), .sram_ce(ce_a)
    );

    sram_arbiter #(.ADDR_BYTES(3), .HALF_DIV(3)) u_dut3 (
        .clk(clk), .resetn(resetn),
        .req0(req0 & sel), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_b), .done0(done0_b),
        .req1(req1 & sel), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_b), .done1(done1_b),
        .rdata(rdata_b), .sclk(sclk_b), .si(si_b), .so(so_m), .sram_ce(ce_b)
    );

    logic        gnt0_m, gnt1_m, done0_m, done1_m, sclk_m, si_m, ce_m;
    logic [31:0] rdata_m;
    assign gnt0_m  = sel ? gnt0_b  : gnt0_a;
    assign gnt1_m  = sel ? gnt1_b  : gnt1_a;
    assign done0_m = sel ? done0_b : done0_a;
    assign done1_m = sel ? done1_b : done1_a;
    assign sclk_m  = sel ? sclk_b  : sclk_a;
    assign si_m    = sel ? si_b    : si_a;
    assign ce_m    = sel ? ce_b    : ce_a;
    assign rdata_m = sel ? rdata_b : rdata_a;

    // ---------------- SPI SRAM model (3 address bytes, sequential mode)
    logic [7:0]  mem [0:255];
    logic [7:0]  log_b [0:15];
    int          nlog = 0;
    int          bits_m = 0;
    int          rd_bits = 0;
    logic [7:0]  sh_m = 8'h00;
    logic [23:0] maddr = 24'h0;
    logic        mwe = 1'b0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always @(negedge ce_m) begin
        bits_m  = 0;
        nlog    = 0;
        rd_bits = 0;
    end

    always @(posedge sclk_m) begin
        if (!ce_m) begin
            sh_m = {sh_m[6:0], si_m};
            bits_m++;
            if (bits_m % 8 == 0) begin
                if (nlog < 16) log_b[nlog] = sh_m;
                nlog++;
                if (bits_m == 8)
                    mwe = (sh_m == 8'h02);
                else if (bits_m <= 32)
                    maddr = {maddr[15:0], sh_m};
                else if (mwe)
                    mem[8'(maddr[7:0] + 8'((bits_m - 40) / 8))] = sh_m;
            end
        end
    end

    always @(negedge sclk_m) begin
        logic [7:0] b;
        if (!ce_m && !mwe && bits_m >= 32) begin
            b    = mem[8'(maddr[7:0] + 8'(rd_bits / 8))];
            so_m = b[7 - (rd_bits % 8)];
            rd_bits++;
        end
    end

    // ---------------- sclk phase-length monitor (HALF_DIV=3 instance)
    int run = 0, hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
    logic prev_sclk = 1'b0;
    bit had_fall = 0;
    always @(negedge clk) begin
        if (sel && !ce_m) begin
            if (sclk_m == prev_sclk) run++;
            else begin
                if (prev_sclk) begin
                    if (run < hi_min) hi_min = run;
                    if (run > hi_max) hi_max = run;
                    had_fall = 1;
                end else if (had_fall) begin
                    if (run < lo_min) lo_min = run;
                    if (run > lo_max) lo_max = run;
                end
                run = 1;
            end
            prev_sclk = sclk_m;
        end else begin
            prev_sclk = 1'b0;
            run       = 0;
            had_fall  = 0;
        end
    end

    int done1_cnt = 0;
    always @(negedge clk) if (done1_a) done1_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure gnt->done latency, optionally check rdata.
    task automatic run_txn(input bit p, input bit we, input logic [1:0] sz,
                           input logic [23:0] a, input logic [31:0] wd,
                           input int exp_lat, input bit is_rd,
                           input logic [31:0] exp_rd, input string tag);
        int g, d;
        bit seen;
        g = 0;
        d = 0;
        @(negedge clk);
        if (!p) begin req0 = 1; we0 = we; size0 = sz; addr0 = a; wdata0 = wd; end
        else    begin req1 = 1; we1 = we; size1 = sz; addr1 = a; wdata1 = wd; end
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (p ? gnt1_m : gnt0_m) begin seen = 1; g = cyc; end
        end
        chk({tag, "_gnt"}, 64'(seen), 64'd1);
        if (seen) begin
            seen = 0;
            for (int i = 0; i < 1000 && !seen; i++) begin
                @(negedge clk);
                if (p ? done1_m : done0_m) begin seen = 1; d = cyc; end
            end
            chk({tag, "_done"}, 64'(seen), 64'd1);
            if (seen) chk({tag, "_lat"}, 64'(d - g), 64'(exp_lat));
            if (seen && is_rd) chk({tag, "_rdata"}, 64'(rdata_m), 64'(exp_rd));
        end
        req0 = 0;
        req1 = 0;
    endtask

    initial begin
        int p, g, last_done, ce_hi, expp, snap;
        bit seen;
        p = 0; g = 0; last_done = 0; expp = 0;

        // ---- reset values
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(sclk_a), 64'd0);
        chk("rst_si", 64'(si_a), 64'd0);
        chk("rst_ce", 64'(ce_a), 64'd1);
        chk("rst_gnt", 64'({gnt0_a, gnt1_a}), 64'd0);
        chk("rst_done", 64'({done0_a, done1_a}), 64'd0);
        chk("rst_rdata", 64'(rdata_a), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // ---- both ports requesting continuously: round-robin
        req0 = 1; we0 = 1; size0 = 0; addr0 = 24'h20; wdata0 = 32'h11;
        req1 = 1; we1 = 1; size1 = 0; addr1 = 24'h21; wdata1 = 32'h22;
        for (int k = 0; k < 4; k++) begin
            seen  = 0;
            ce_hi = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (gnt0_m || gnt1_m) begin seen = 1; p = gnt1_m; g = cyc; end
                else if (ce_m) ce_hi++;
            end
            chk("alt_gnt_seen", 64'(seen), 64'd1);
`ifdef SRAM_ARB_FIXED_PRIO_EN
            expp = 0;
`else
            expp = k % 2;
`endif
            chk("alt_port", 64'(p), 64'(expp));
            if (k > 0) chk("alt_ce_gap", 64'(ce_hi + 1), 64'd2);
            seen = 0;
            for (int i = 0; i < 500 && !seen; i++) begin
                @(negedge clk);
                if (p ? done1_m : done0_m) seen = 1;
            end
            chk("alt_done", 64'(seen), 64'd1);
            if (k == 0) chk("alt_lat", 64'(cyc - g), 64'd82);
            chk("alt_ce_done", 64'(ce_m), 64'd1);
            last_done = cyc;
            if (k == 3) begin req0 = 0; req1 = 0; end
        end
        repeat (3) @(negedge clk);

        // ---- port 0 write 4 bytes
        run_txn(0, 1, 2'd2, 24'h000010, 32'hDEADBEEF, 130, 0, 32'h0, "wr4");
        chk("wr4_nbytes", 64'(nlog), 64'd8);
        chk("wr4_stream", {log_b[0], log_b[1], log_b[2], log_b[3],
                           log_b[4], log_b[5], log_b[6], log_b[7]}, 64'h02000010EFBEADDE);
        chk("wr4_mem", 64'({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}), 64'hDEADBEEF);

        // ---- port 0 read 2 bytes
        run_txn(0, 0, 2'd1, 24'h000012, 32'h0, 98, 1, 32'h0000DEAD, "rd2");

        // ---- reset during the ADDR phase of a port 1 read
        @(negedge clk);
        req1 = 1; we1 = 0; size1 = 0; addr1 = 24'h10;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (gnt1_m) seen = 1;
        end
        chk("rst_mid_gnt", 64'(seen), 64'd1);
        repeat (30) @(negedge clk);
        chk("rst_mid_active", 64'(ce_m), 64'd0);
        snap   = done1_cnt;
        resetn = 1'b0;
        #1;
        chk("rst_mid_ce", 64'(ce_a), 64'd1);
        chk("rst_mid_sclk", 64'(sclk_a), 64'd0);
        req1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_mid_rdata", 64'(rdata_a), 64'd0);
        resetn = 1'b1;
        repeat (150) @(negedge clk);
        chk("rst_mid_no_done", 64'(done1_cnt - snap), 64'd0);
        run_txn(1, 0, 2'd0, 24'h000010, 32'h0, 82, 1, 32'h000000EF, "rd_after_rst");

        // ---- HALF_DIV=3 instance, size 3 read treated as 4 bytes
        @(negedge clk);
        sel = 1'b1;
        run_txn(0, 0, 2'd3, 24'h000010, 32'h0, 386, 1, 32'hDEADBEEF, "hd3");
        chk("hd3_hi_min", 64'(hi_min), 64'd3);
        chk("hd3_hi_max", 64'(hi_max), 64'd3);
        chk("hd3_lo_min", 64'(lo_min), 64'd3);
        chk("hd3_lo_max", 64'(lo_max), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
